// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared state encoding and sizing for the truth-table sequencer
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_IN_DEFAULT  = 3;
  localparam int DWELL_DEFAULT = 50;

  // Number of input combinations swept for a function of n inputs.
  function automatic int nvec(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// rtl/truth_table_sequencer_dwell_timer.sv - per-vector hold counter, ticks on the last dwell cycle
module dwell_timer #(
  parameter int DWELL = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // DWELL=1 would give a zero-width counter; keep one bit that simply stays at zero.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Count 0..DWELL-1 while enabled, wrapping on the tick; clear restarts a sweep.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors, captures F and checks Fn complement
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter  int N_IN  = N_IN_DEFAULT,
  parameter  int DWELL = DWELL_DEFAULT,
  localparam int NVEC  = nvec(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            f_in,
  input  logic            fn_in,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic [NVEC-1:0] result,
  output logic            err,
  output logic [N_IN:0]   err_count
);

  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [NVEC-1:0] result_q, result_d;
  logic            err_q, err_d;
  logic [N_IN:0]   errc_q, errc_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tmr_clear;
  logic            tmr_tick;

  dwell_timer #(.DWELL(DWELL)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (state_q == DRIVE),
    .tick   (tmr_tick)
  );

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign err_count = errc_q;

  // Next-state logic: accept start in IDLE, sample at each dwell end, abort wins over completion.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    result_d  = result_q;
    err_d     = err_q;
    errc_d    = errc_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRIVE;
          vec_d     = '0;
          result_d  = '0;
          err_d     = 1'b0;
          errc_d    = '0;
          busy_d    = 1'b1;
          tmr_clear = 1'b1;
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        if (tmr_tick) begin
          result_d[vec_q] = f_in;
          if (fn_in == f_in) begin
            err_d  = 1'b1;
            errc_d = errc_q + 1'b1;
          end
        end
        if (abort) begin
          // Partial results are kept and vec holds where it was.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (tmr_tick) begin
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      errc_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      result_q <= result_d;
      err_q    <= err_d;
      errc_q   <= errc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for the truth-table sequencer
module tb_truth_table_sequencer;

  localparam int DW = 50;

  typedef struct {
    logic [7:0] res;
    logic       err;
    logic [3:0] ec;
    int         dc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic       f_in, fn_in;
  logic [2:0] vec;
  logic       busy, done, err;
  logic [7:0] result;
  logic [3:0] err_count;
  logic [7:0] f_tab, f_mask;

  logic       start2, f_in2, fn_in2;
  logic [1:0] vec2;
  logic       busy2, done2, err2;
  logic [3:0] result2;
  logic [2:0] err_count2;

  // Function block model: F from a truth table, Fn is ~F except where the fault mask forces Fn=F.
  assign f_in  = f_tab[vec];
  assign fn_in = f_mask[vec] ? f_in : ~f_in;

  assign f_in2  = vec2[1] ^ vec2[0];
  assign fn_in2 = ~f_in2;

  truth_table_sequencer #(.N_IN(3), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_in(f_in), .fn_in(fn_in), .vec(vec), .busy(busy), .done(done),
    .result(result), .err(err), .err_count(err_count)
  );

  truth_table_sequencer #(.N_IN(2), .DWELL(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .f_in(f_in2), .fn_in(fn_in2), .vec(vec2), .busy(busy2), .done(done2),
    .result(result2), .err(err2), .err_count(err_count2)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected sweep.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.dc));
        chk("result", 32'(result), 32'(mon_e.res));
        chk("err", 32'(err), 32'(mon_e.err));
        chk("err_count", 32'(err_count), 32'(mon_e.ec));
      end
    end
  end

  task automatic run_main(input logic [7:0] ft, input logic [7:0] fm,
                          input int abort_vec, input bit extra_starts);
    int         ts;
    exp_t       e;
    logic [7:0] low;
    @(negedge clk);
    f_tab  = ft;
    f_mask = fm;
    start  = 1'b1;
    ts     = cyc + 1;
    if (abort_vec < 0) begin
      e.res = ft;
      e.err = (fm != 8'h00);
      e.ec  = 4'($countones(fm));
      e.dc  = ts + 8 * DW;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("result_cleared", 32'(result), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("vec_step", 32'(vec), 32'(k));
      if (k == abort_vec) begin
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        low = 8'((1 << k) - 1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vec_hold", 32'(vec), 32'(k));
        chk("abort_result", 32'(result), 32'(ft & low));
        chk("abort_err_count", 32'(err_count), 32'($countones(fm & low)));
        repeat (8 * DW) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        return;
      end
      if (extra_starts && k == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (DW - 1) @(negedge clk);
      end else begin
        repeat (DW) @(negedge clk);
      end
    end
    chk("done_on_time", 32'(done), 32'd1);
    if (extra_starts) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_vec_hold", 32'(vec), 32'd7);
    repeat (3) @(negedge clk);
    chk("post_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int ts2;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    abort  = 1'b0;
    f_tab  = 8'h00;
    f_mask = 8'h00;
    #3;
    chk("reset_vec", 32'(vec), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Golden F=(x&y)|z, then complement fault on vectors 2 and 5, then abort in vector 4.
    run_main(8'hEA, 8'h00, -1, 1'b0);
    run_main(8'hEA, 8'h24, -1, 1'b0);
    run_main(8'hEA, 8'h00, 4, 1'b0);
    // Starts during DRIVE and during the done cycle must be ignored; next run restarts cleanly.
    run_main(8'hEA, 8'h00, -1, 1'b1);
    run_main(8'h5C, 8'h81, -1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      run_main(8'($urandom), 8'($urandom), -1, 1'b0);
    end
    run_main(8'($urandom), 8'($urandom), int'($urandom_range(1, 7)), 1'b0);

    // Asynchronous reset in the middle of vector 3.
    @(negedge clk);
    f_tab  = 8'hEA;
    f_mask = 8'h01;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * DW + 5) @(negedge clk);
    chk("pre_reset_vec", 32'(vec), 32'd3);
    chk("pre_reset_err", 32'(err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset_vec", 32'(vec), 32'd0);
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_result", 32'(result), 32'd0);
    chk("midrun_reset_err", 32'(err), 32'd0);
    chk("midrun_reset_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8 * DW) @(negedge clk);
    run_main(8'hEA, 8'h00, -1, 1'b0);

    // N_IN=2, DWELL=1 instance sweeping F=y^z.
    @(negedge clk);
    start2 = 1'b1;
    ts2    = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    seen   = -1;
    for (int i = 0; i < 10; i++) begin
      if (done2 && seen < 0) seen = cyc;
      @(negedge clk);
    end
    chk("dwell1_done_cycle", 32'(seen), 32'(ts2 + 4));
    chk("dwell1_result", 32'(result2), 32'h6);
    chk("dwell1_err", 32'(err2), 32'd0);
    chk("dwell1_err_count", 32'(err_count2), 32'd0);
    chk("dwell1_vec_hold", 32'(vec2), 32'd3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
